// File: rtl/mips_dmem_responder.sv
// Wait-state data memory for the MIPS core's data port: one request at a time,
// fixed LATENCY between accept and response, and a valid/ready response channel.
module mips_dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [1:0]        fsm_state
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; valid never depends on ready, and payloads hold while valid waits.

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   MEM1 [DEPTH];
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic                commit;

  assign in_range  = (32'(addr_q) < 32'(DEPTH));
  assign idx       = addr_q[IDX_W-1:0];
  assign commit    = (state == WAIT) && (cnt == 4'd0) && we_q && in_range;
  assign fsm_state = state;

  // Array has no reset; an async reset forces state to IDLE, which drops commit.
  always_ff @(posedge clock) begin
    if (commit) MEM1[idx] <= wdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= CNT_INIT;
            state     <= WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= (!we_q && in_range) ? MEM1[idx] : '0;
            rsp_err   <= !in_range;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            if (we_q) begin
              if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
              if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: expected responses are queued at issue
// time and a monitor pops and compares them on every response handshake.
module tb_mips_dmem_responder;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic              clock;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;
  logic [1:0]        fsm_state;

  mips_dmem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .rd_count(rd_count), .wr_count(wr_count),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard: {err, data}
  logic [DATA_W:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor
  logic prev_v = 1'b0;
  always @(negedge clock) begin
    if (rsp_valid && !prev_v) chk("latency", 64'(cyc - acc_cyc), 64'(LATENCY));
    prev_v = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_rdata), 64'hDEAD_0000_0000);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[DATA_W-1:0]));
        chk("rsp_err", 64'(rsp_err), 64'(e[DATA_W]));
      end
    end
  end

  // driver tasks
  task automatic send(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, input logic exp_err,
                      input logic [DATA_W-1:0] exp_data, input logic push);
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clock); n++; end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    if (push) exp_q.push_back({exp_err, exp_data});
    @(posedge clock);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || busy) && n < 100) begin @(negedge clock); n++; end
    if (exp_q.size() != 0 || busy) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_rd_count"},  64'(rd_count),  64'd0);
    chk({tag, "_wr_count"},  64'(wr_count),  64'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset_outputs("por");
    reset = 1'b0;
    @(negedge clock);

    // store then load, same address
    send(1'b1, 9'd0, 32'd5, 1'b0, 32'd0, 1'b1);
    drain();
    chk("wr_count_1", 64'(wr_count), 64'd1);
    send(1'b0, 9'd0, 32'd0, 1'b0, 32'h0000_0005, 1'b1);
    drain();
    chk("rd_count_1", 64'(rd_count), 64'd1);
    send(1'b1, 9'd4, 32'h0000_000A, 1'b0, 32'd0, 1'b1);
    send(1'b0, 9'd4, 32'd0, 1'b0, 32'h0000_000A, 1'b1);
    drain();
    chk("wr_count_2", 64'(wr_count), 64'd2);
    chk("rd_count_2", 64'(rd_count), 64'd2);

    // backpressure
    rsp_ready = 1'b0;
    send(1'b0, 9'd0, 32'd0, 1'b0, 32'h0000_0005, 1'b1);
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
      if (!rsp_valid) chk("bp_rsp_timeout", 64'(rsp_valid), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rdata", 64'(rsp_rdata), 64'h0000_0005);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clock);
    end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("bp_idle_req_ready", 64'(req_ready), 64'd1);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("rd_count_3", 64'(rd_count), 64'd3);

    // out-of-range: 300 must not alias onto word 44
    send(1'b1, 9'd44, 32'h0000_002C, 1'b0, 32'd0, 1'b1);
    send(1'b1, 9'd300, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b1);
    send(1'b0, 9'd300, 32'd0, 1'b1, 32'd0, 1'b1);
    send(1'b0, 9'd44, 32'd0, 1'b0, 32'h0000_002C, 1'b1);
    drain();
    chk("wr_count_err", 64'(wr_count), 64'd4);
    chk("rd_count_err", 64'(rd_count), 64'd5);

    // reset during WAIT abandons the store
    send(1'b1, 9'd8, 32'h0000_0011, 1'b0, 32'd0, 1'b1);
    drain();
    send(1'b1, 9'd8, 32'h0000_0099, 1'b0, 32'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    send(1'b0, 9'd8, 32'd0, 1'b0, 32'h0000_0011, 1'b1);
    drain();
    chk("rd_after_rst", 64'(rd_count), 64'd1);
    chk("wr_after_rst", 64'(wr_count), 64'd0);

    // saturation
    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 9'd12, 32'(i), 1'b0, 32'd0, 1'b1);
      drain();
      chk("wr_count_sat", 64'(wr_count), 64'hFFFF);
    end
    chk("rd_count_sat_untouched", 64'(rd_count), 64'd1);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
